// File: rtl/al_restart_pkg.sv
// rtl/al_restart_pkg.sv - state encoding, timer width and register bundle shared by al_restart_req
package al_restart_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_READY     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_DROP = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    // Everything that is registered, kept in one bundle so it can be triplicated as a unit.
    typedef struct packed {
        state_t               state;
        logic [TIMER_W-1:0]   timer;
        logic [1:0]           retry_cnt;
        logic                 pending;
        logic                 al_restart;
        logic                 ready;
        logic                 busy;
        logic                 timeout_err;
    } regs_t;

    localparam regs_t REGS_RST = '{
        state:       ST_BOOT,
        timer:       '0,
        retry_cnt:   2'd0,
        pending:     1'b0,
        al_restart:  1'b0,
        ready:       1'b0,
        busy:        1'b1,
        timeout_err: 1'b0
    };

    function automatic logic is_waiting(input state_t s);
        return (s == ST_BOOT) || (s == ST_WAIT_DROP) || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// rtl/tmr_vote.sv - bitwise 2-of-3 majority voter
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/al_restart_req.sv
// rtl/al_restart_req.sv - FIFO reset handshake initiator: AL_RESTART pulse, DONE tracking, bounded retry
// Define AL_RESTART_REQ_TMR_EN to triplicate all registers behind majority voters.
module al_restart_req
    import al_restart_pkg::*;
#(
    parameter int DROP_TO   = 8,
    parameter int DONE_TO   = 63,
    parameter int MAX_RETRY = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       DONE,
    input  logic       CLR_ERR,
    output logic       AL_RESTART,
    output logic       READY,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    output logic [1:0] RETRY_CNT
);

    localparam logic [TIMER_W-1:0] DROP_LIM  = TIMER_W'(DROP_TO - 1);
    localparam logic [TIMER_W-1:0] DONE_LIM  = TIMER_W'(DONE_TO - 1);
    localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRY);

    regs_t cur;

    function automatic regs_t next_regs(input regs_t c, input logic req, input logic done,
                                        input logic clr_err);
        regs_t  n;
        state_t ns;
        logic   retry_now;
        n         = c;
        ns        = c.state;
        retry_now = 1'b0;
        case (c.state)
            ST_BOOT: begin
                n.pending = c.pending | req;
                if (done)
                    ns = ST_READY;
                else if (c.timer == DONE_LIM)
                    ns = ST_ERROR;
            end
            ST_READY: begin
                if (req || c.pending) begin
                    ns          = ST_PULSE;
                    n.pending   = 1'b0;
                    n.retry_cnt = 2'd0;
                end else if (!done) begin
                    ns = ST_WAIT_DONE;
                end
            end
            ST_PULSE: begin
                n.pending = c.pending | req;
                ns        = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                // A DONE rise here is a glitch; only a fall advances.
                n.pending = c.pending | req;
                if (!done)
                    ns = ST_WAIT_DONE;
                else if (c.timer == DROP_LIM)
                    retry_now = 1'b1;
            end
            ST_WAIT_DONE: begin
                n.pending = c.pending | req;
                if (done)
                    ns = ST_READY;
                else if (c.timer == DONE_LIM)
                    retry_now = 1'b1;
            end
            ST_ERROR: begin
                if (clr_err) begin
                    ns          = ST_BOOT;
                    n.retry_cnt = 2'd0;
                    n.pending   = c.pending | req;
                end else if (req) begin
                    ns          = ST_PULSE;
                    n.retry_cnt = 2'd0;
                    n.pending   = 1'b0;
                end
            end
            default: ns = ST_BOOT;
        endcase

        if (retry_now) begin
            if (c.retry_cnt < RETRY_MAX) begin
                ns          = ST_PULSE;
                n.retry_cnt = c.retry_cnt + 2'd1;
            end else begin
                ns = ST_ERROR;
            end
        end

        if (ns != c.state)
            n.timer = '0;
        else if (is_waiting(c.state) && (c.timer != '1))
            n.timer = c.timer + TIMER_W'(1);

        // Outputs are decoded from the next state so they line up with it.
        n.state       = ns;
        n.al_restart  = (ns == ST_PULSE);
        n.ready       = (ns == ST_READY);
        n.busy        = (ns == ST_BOOT) || (ns == ST_PULSE) ||
                        (ns == ST_WAIT_DROP) || (ns == ST_WAIT_DONE);
        n.timeout_err = (ns == ST_ERROR);
        return n;
    endfunction

`ifdef AL_RESTART_REQ_TMR_EN
    localparam int RW = $bits(regs_t);

    (* syn_keep = 1 *) logic [RW-1:0] voted;

    for (genvar i = 0; i < 3; i++) begin : g_copy
        (* syn_preserve = 1 *) logic [RW-1:0] q;
        always_ff @(posedge CLK) begin
            if (RST)
                q <= REGS_RST;
            else
                q <= next_regs(cur, REQ, DONE, CLR_ERR);
        end
    end

    tmr_vote #(.W(RW)) u_vote (
        .a (g_copy[0].q),
        .b (g_copy[1].q),
        .c (g_copy[2].q),
        .y (voted)
    );

    assign cur = regs_t'(voted);
`else
    regs_t regs_q;

    always_ff @(posedge CLK) begin
        if (RST)
            regs_q <= REGS_RST;
        else
            regs_q <= next_regs(cur, REQ, DONE, CLR_ERR);
    end

    assign cur = regs_q;
`endif

    assign AL_RESTART  = cur.al_restart;
    assign READY       = cur.ready;
    assign BUSY        = cur.busy;
    assign TIMEOUT_ERR = cur.timeout_err;
    assign RETRY_CNT   = cur.retry_cnt;

endmodule

// File: tb/tb_al_restart_req.sv
// tb/tb_al_restart_req.sv - self-checking bench for al_restart_req with a reactive sequencer model
module tb_al_restart_req;

    localparam int DROP_TO   = 8;
    localparam int DONE_TO   = 63;
    localparam int MAX_RETRY = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic       DONE = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic       AL_RESTART;
    logic       READY;
    logic       BUSY;
    logic       TIMEOUT_ERR;
    logic [1:0] RETRY_CNT;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int al_cnt = 0;
    int al_times[$];

    // Sequencer model: after seeing AL_RESTART it drops DONE dd cycles later, raises it rr after that.
    bit seq_on = 1'b0;
    int dd = 1;
    int rr = 2;
    int drop_at = -1;
    int rise_at = -1;

    al_restart_req #(
        .DROP_TO   (DROP_TO),
        .DONE_TO   (DONE_TO),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .DONE        (DONE),
        .CLR_ERR     (CLR_ERR),
        .AL_RESTART  (AL_RESTART),
        .READY       (READY),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .RETRY_CNT   (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        if (AL_RESTART === 1'b1) begin
            al_cnt++;
            al_times.push_back(cyc);
            if (seq_on) begin
                drop_at = cyc + dd;
                rise_at = cyc + dd + rr;
            end
        end
        if (seq_on && (cyc + 1 == drop_at)) DONE = 1'b0;
        if (seq_on && (cyc + 1 == rise_at)) DONE = 1'b1;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        drop_at = -1;
        rise_at = -1;
        repeat (n) step();
        RST = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            step();
            if (READY === 1'b1) at = cyc;
        end
    endtask

    task automatic wait_err(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            step();
            if (TIMEOUT_ERR === 1'b1) at = cyc;
        end
    endtask

    initial begin
        int r, at, p, d, n0;

        DONE = 1'b0;
        do_reset(2);
        r = cyc;
        chk("rst_ready", READY, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_al", AL_RESTART, 0);
        chk("rst_terr", TIMEOUT_ERR, 0);
        chk("rst_retry", RETRY_CNT, 0);

        // Boot with DONE never rising times out after DONE_TO cycles
        n0 = al_cnt;
        wait_err(200, at);
        chk("boot_timeout_at", at, r + DONE_TO);
        chk("boot_timeout_no_pulse", al_cnt - n0, 0);
        chk("err_busy", BUSY, 0);

        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
        chk("clr_busy", BUSY, 1);
        chk("clr_terr", TIMEOUT_ERR, 0);

        // Boot with the sequencer coming up after a random delay
        do_reset(2);
        r = cyc;
        d = $urandom_range(3, 40);
        n0 = al_cnt;
        at = -1;
        for (int i = 0; i < 100 && at < 0; i++) begin
            if (cyc + 1 == r + d) DONE = 1'b1;
            step();
            if (READY === 1'b1) at = cyc;
        end
        chk("boot_ready_at", at, r + d);
        chk("boot_busy", BUSY, 0);
        chk("boot_no_pulse", al_cnt - n0, 0);

        // Normal restarts with random sequencer timing
        seq_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dd = $urandom_range(1, 6);
            rr = $urandom_range(2, 40);
            n0 = al_cnt;
            REQ = 1'b1;
            step();
            REQ = 1'b0;
            p = cyc;
            chk("req_to_pulse", AL_RESTART, 1);
            step();
            chk("pulse_one_cycle", AL_RESTART, 0);
            wait_ready(150, at);
            chk("restart_ready_at", at, p + dd + rr);
            chk("restart_pulses", al_cnt - n0, 1);
            chk("restart_retry", RETRY_CNT, 0);
        end

        // Five requests while busy coalesce into one extra restart
        dd = $urandom_range(1, 6);
        rr = $urandom_range(14, 40);
        n0 = al_cnt;
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        p = cyc;
        for (int i = 0; i < 5; i++) begin
            REQ = 1'b1;
            step();
            REQ = 1'b0;
            step();
        end
        wait_ready(150, at);
        chk("coal_ready_at", at, p + dd + rr);
        step();
        chk("coal_repulse", AL_RESTART, 1);
        p = cyc;
        wait_ready(150, at);
        chk("coal_ready2_at", at, p + dd + rr);
        repeat (10) step();
        chk("coal_pulses", al_cnt - n0, 2);

        // Unsolicited DONE drop while Ready
        seq_on = 1'b0;
        n0 = al_cnt;
        DONE = 1'b0;
        step();
        chk("drop_busy", BUSY, 1);
        chk("drop_ready", READY, 0);
        d = $urandom_range(1, 30);
        repeat (d) step();
        DONE = 1'b1;
        step();
        chk("drop_back_ready", READY, 1);
        chk("drop_no_pulse", al_cnt - n0, 0);

        // DONE stuck low: retries spaced by Pulse + Wait_Drop + DONE_TO
        n0 = al_cnt;
        al_times.delete();
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        DONE = 1'b0;
        p = cyc;
        wait_err(400, at);
        chk("stuck_pulses", al_cnt - n0, MAX_RETRY + 1);
        for (int i = 0; i < MAX_RETRY + 1; i++)
            chk("stuck_pulse_time", (al_times.size() > i) ? al_times[i] : -1, p + i * (DONE_TO + 2));
        chk("stuck_err_at", at, p + (MAX_RETRY + 1) * (DONE_TO + 2));
        chk("stuck_retry", RETRY_CNT, MAX_RETRY);
        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
        chk("stuck_clr_busy", BUSY, 1);
        chk("stuck_clr_retry", RETRY_CNT, 0);
        DONE = 1'b1;
        step();
        chk("stuck_clr_ready", READY, 1);

        // DONE never drops: retries spaced by Pulse + DROP_TO, then REQ from Error recovers
        n0 = al_cnt;
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        p = cyc;
        wait_err(100, at);
        chk("nodrop_err_at", at, p + (MAX_RETRY + 1) * (DROP_TO + 1));
        chk("nodrop_pulses", al_cnt - n0, MAX_RETRY + 1);
        seq_on = 1'b1;
        dd = $urandom_range(1, 6);
        rr = $urandom_range(2, 40);
        REQ = 1'b1;
        step();
        REQ = 1'b0;
        p = cyc;
        chk("err_req_pulse", AL_RESTART, 1);
        chk("err_req_retry", RETRY_CNT, 0);
        wait_ready(150, at);
        chk("err_req_ready_at", at, p + dd + rr);

        // Reset during the Pulse cycle kills the pulse and any pending request
        seq_on = 1'b0;
        REQ = 1'b1;
        step();
        chk("rstp_pulse", AL_RESTART, 1);
        RST = 1'b1;
        step();
        chk("rstp_al", AL_RESTART, 0);
        chk("rstp_busy", BUSY, 1);
        RST = 1'b0;
        REQ = 1'b0;
        DONE = 1'b1;
        step();
        chk("rstp_ready", READY, 1);
        n0 = al_cnt;
        repeat (3) step();
        chk("rstp_no_pending", al_cnt - n0, 0);
        chk("rstp_still_ready", READY, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
